slow_tick_counter: RTL and testbench



---
 rtl/slow_tick_pkg.sv | 15 +
 rtl/slow_tick_counter_edge_sync.sv | 28 ++
 rtl/slow_tick_counter.sv | 106 ++++++++++
 tb/tb_slow_tick_counter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slow_tick_pkg.sv
// Shared definitions for the slow tick counter: run-control FSM encoding
// and default build parameters.
package slow_tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } run_state_t;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_MAX         = 9;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/slow_tick_counter_edge_sync.sv
// Synchroniser chain plus registered rising-edge detector for an async level
// input; reusable for slow clocks and push-button inputs.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic d_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   prev_p1;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_p0    <= '0;
            prev_p1    <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_p0    <= {sync_p0[SYNC_STAGES-2:0], d_in};
            // stage boundary: edge detect on the fully synchronised level
            prev_p1    <= sync_p0[SYNC_STAGES-1];
            rise_pulse <= sync_p0[SYNC_STAGES-1] & ~prev_p1;
        end
    end

endmodule

// File: rtl/slow_tick_counter.sv
// Counts synchronised rising edges of slow_in modulo MAX+1 under start/stop/clr
// run control. Build macro SLOW_TICK_DOWN_EN adds a dir input for down-counting.
module slow_tick_counter
    import slow_tick_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MAX         = DEF_MAX,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             slow_in,
    input  logic             start,
    input  logic             stop,
    input  logic             clr,
`ifdef SLOW_TICK_DOWN_EN
    input  logic             dir,
`endif
    output logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             running
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    run_state_t       state_q;
    run_state_t       state_d;
    logic [WIDTH:0]   step;
    logic             count_en;

    // Result is {wrap, next_count}.
    function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] c);
        if (c == MAX_W) begin
            return {1'b1, {WIDTH{1'b0}}};
        end
        return {1'b0, c + ONE_W};
    endfunction

`ifdef SLOW_TICK_DOWN_EN
    function automatic logic [WIDTH:0] step_down(input logic [WIDTH-1:0] c);
        if (c == '0) begin
            return {1'b1, MAX_W};
        end
        return {1'b0, c - ONE_W};
    endfunction
`endif

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk_in    (clk_in),
        .rst       (rst),
        .d_in      (slow_in),
        .rise_pulse(tick)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: if (start && !stop) state_d = ST_RUN;
                ST_RUN:            if (stop) state_d = ST_PAUSE;
                default:           state_d = ST_IDLE;
            endcase
        end
    end

    assign running  = (state_q == ST_RUN);
    // A tick landing while still in IDLE/PAUSE is not counted, even on a start cycle.
    assign count_en = (state_q == ST_RUN) && tick;

    always_comb begin
        step = step_up(count);
`ifdef SLOW_TICK_DOWN_EN
        if (dir) step = step_down(count);
`endif
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (count_en) begin
            count <= step[WIDTH-1:0];
            wrap  <= step[WIDTH];
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_slow_tick_counter.sv
// Bench for slow_tick_counter: fixed vector table, directed multi-cycle
// sequences and randomised run against a behavioural model.
module tb_slow_tick_counter;

    localparam int WIDTH = 8;
    localparam int MAX   = 9;
    localparam int S     = 2;
`ifdef SLOW_TICK_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic             clk_in = 1'b0;
    logic             rst, slow_in, start, stop, clr, dir;
    logic             tick, wrap, running;
    logic [WIDTH-1:0] count;

    slow_tick_counter #(.WIDTH(WIDTH), .MAX(MAX), .SYNC_STAGES(S)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .slow_in(slow_in),
        .start  (start),
        .stop   (stop),
        .clr    (clr),
`ifdef SLOW_TICK_DOWN_EN
        .dir    (dir),
`endif
        .tick   (tick),
        .count  (count),
        .wrap   (wrap),
        .running(running)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int st, sp, cl, sl;
        int tk, cnt, wr, rn;
    } vec_t;
    vec_t tbl[18];

    int n_vec = 0, n_bad = 0, tick_seen = 0, wrap_seen = 0;

    // Behavioural model: sample history, run mode (0 idle, 1 run, 2 pause), count.
    bit m_hist[0:S+1];
    bit m_tick, m_wrap;
    int m_cnt, m_state;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j <= S + 1; j++) m_hist[j] = 1'b0;
        m_tick = 0; m_wrap = 0; m_cnt = 0; m_state = 0;
    endtask

    task automatic model_edge();
        bit t_old = m_tick;
        int s_old = m_state;
        for (int j = S + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = slow_in;
        m_tick = m_hist[S] & ~m_hist[S+1];
        m_wrap = 0;
        if (clr) begin
            m_cnt = 0;
        end else if (s_old == 1 && t_old) begin
            if (DOWN_EN && dir) begin
                m_cnt  = (m_cnt + MAX) % (MAX + 1);
                m_wrap = (m_cnt == MAX);
            end else begin
                m_cnt  = (m_cnt + 1) % (MAX + 1);
                m_wrap = (m_cnt == 0);
            end
        end
        if (clr) m_state = 0;
        else if (s_old == 1) m_state = stop ? 2 : 1;
        else if (start && !stop) m_state = 1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".tick"},    tick,    m_tick);
        chk({tag, ".count"},   count,   m_cnt);
        chk({tag, ".wrap"},    wrap,    m_wrap);
        chk({tag, ".running"}, running, (m_state == 1));
    endtask

    task automatic cyc(input int st, sp, cl, sl, dr, input bit vs_model, input string tag);
        start = (st != 0); stop = (sp != 0); clr = (cl != 0);
        slow_in = (sl != 0); dir = (dr != 0);
        @(posedge clk_in);
        model_edge();
        #1;
        tick_seen += tick;
        wrap_seen += wrap;
        if (vs_model) check_model(tag);
    endtask

    // One slow_in pulse; run-control inputs are applied on the cycle the tick is high.
    task automatic pulse(input int st, sp, cl, dr, input string tag);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, dr, 1, tag);
        cyc(st, sp, cl, 1, dr, 1, tag);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, dr, 1, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected end before 500000");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0,0,0,1, 0,0,0,0};
        tbl[1]  = '{0,0,0,1, 0,0,0,0};
        tbl[2]  = '{0,0,0,1, 1,0,0,0};
        tbl[3]  = '{1,0,0,1, 0,0,0,1};
        tbl[4]  = '{0,0,0,0, 0,0,0,1};
        tbl[5]  = '{0,0,0,0, 0,0,0,1};
        tbl[6]  = '{0,0,0,1, 0,0,0,1};
        tbl[7]  = '{0,0,0,1, 0,0,0,1};
        tbl[8]  = '{0,0,0,1, 1,0,0,1};
        tbl[9]  = '{1,1,0,1, 0,1,0,0};
        tbl[10] = '{0,0,0,0, 0,1,0,0};
        tbl[11] = '{0,0,0,0, 0,1,0,0};
        tbl[12] = '{0,0,0,1, 0,1,0,0};
        tbl[13] = '{0,0,0,1, 0,1,0,0};
        tbl[14] = '{0,0,0,1, 1,1,0,0};
        tbl[15] = '{1,0,0,1, 0,1,0,1};
        tbl[16] = '{0,0,0,0, 0,1,0,1};
        tbl[17] = '{0,0,1,0, 0,0,0,0};

        rst = 1'b1; slow_in = 1'b0; start = 1'b0; stop = 1'b0; clr = 1'b0; dir = 1'b0;
        model_reset();
        #12;
        chk("reset.tick", tick, 0);
        chk("reset.count", count, 0);
        chk("reset.wrap", wrap, 0);
        chk("reset.running", running, 0);
        #10 rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].st, tbl[i].sp, tbl[i].cl, tbl[i].sl, 0, 0, "tbl");
            chk($sformatf("tbl[%0d].tick", i), tick, tbl[i].tk);
            chk($sformatf("tbl[%0d].count", i), count, tbl[i].cnt);
            chk($sformatf("tbl[%0d].wrap", i), wrap, tbl[i].wr);
            chk($sformatf("tbl[%0d].running", i), running, tbl[i].rn);
        end

        // Count through MAX and wrap.
        cyc(1, 0, 0, 0, 0, 1, "count");
        wrap_seen = 0;
        for (int k = 1; k <= 10; k++) begin
            pulse(0, 0, 0, 0, "count");
            if (k == 9) chk("count.nine", count, 9);
        end
        chk("count.wrapped", count, 0);
        chk("count.wrap_once", wrap_seen, 1);
        chk("count.running", running, 1);

        // Stop wins over start, tick on the stop cycle still counts.
        for (int k = 0; k < 4; k++) pulse(0, 0, 0, 0, "stop");
        chk("stop.four", count, 4);
        pulse(1, 1, 0, 0, "stop");
        chk("stop.count", count, 5);
        chk("stop.running", running, 0);
        pulse(0, 0, 0, 0, "pause");
        pulse(0, 0, 0, 0, "pause");
        chk("pause.hold", count, 5);
        cyc(1, 0, 0, 0, 0, 1, "resume");
        pulse(0, 0, 0, 0, "resume");
        chk("resume.count", count, 6);

        // Clear beats a coincident tick.
        pulse(0, 0, 0, 0, "clr");
        chk("clr.seven", count, 7);
        pulse(0, 0, 1, 0, "clr");
        chk("clr.count", count, 0);
        chk("clr.running", running, 0);
        pulse(0, 0, 0, 0, "clr_idle");
        pulse(0, 0, 0, 0, "clr_idle");
        chk("clr.idle_hold", count, 0);
        cyc(1, 0, 0, 0, 0, 1, "clr_restart");
        pulse(0, 0, 0, 0, "clr_restart");
        chk("clr.restart", count, 1);

`ifdef SLOW_TICK_DOWN_EN
        cyc(0, 0, 1, 0, 1, 1, "down");
        cyc(1, 0, 0, 0, 1, 1, "down");
        wrap_seen = 0;
        pulse(0, 0, 0, 1, "down");
        chk("down.wrap_to_max", count, MAX);
        chk("down.wrap_once", wrap_seen, 1);
        pulse(0, 0, 0, 1, "down");
        chk("down.dec", count, MAX - 1);
`endif

        // Async reset mid-run with slow_in held high through release.
        cyc(0, 0, 1, 0, 0, 1, "arst");
        cyc(1, 0, 0, 0, 0, 1, "arst");
        for (int k = 0; k < 3; k++) pulse(0, 0, 0, 0, "arst");
        chk("arst.three", count, 3);
        slow_in = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst.tick", tick, 0);
        chk("arst.count", count, 0);
        chk("arst.wrap", wrap, 0);
        chk("arst.running", running, 0);
        model_reset();
        @(posedge clk_in);
        #3 rst = 1'b0;
        tick_seen = 0;
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1, 0, 1, "arst_rel");
        chk("arst.one_tick", tick_seen, 1);
        chk("arst.uncounted", count, 0);

        // Randomised run-control and slow_in activity.
        begin
            int sl = 0;
            for (int n = 0; n < 600; n++) begin
                if ($urandom_range(0, 2) == 0) sl = 1 - sl;
                cyc(($urandom_range(0, 3) == 0) ? 1 : 0,
                    ($urandom_range(0, 15) == 0) ? 1 : 0,
                    ($urandom_range(0, 63) == 0) ? 1 : 0,
                    sl,
                    ($urandom_range(0, 7) == 0) ? 1 : 0,
                    1, "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
